// File: rtl/axi_lite_reg_responder.sv
// axi_lite_reg_responder: AXI4-Lite subordinate with a byte-strobed register file,
// a read-only ID word at register 0 and write/read/error transaction counters.
// Ports:
//   clk_wr, rst_wr_n           clock and asynchronous active-low reset
//   awaddr/awvalid/awready     write address channel
//   wdata/wstrb/wvalid/wready  write data channel
//   bresp/bvalid/bready        write response channel
//   araddr/arvalid/arready     read address channel
//   rdata/rresp/rvalid/rready  read data channel
//   wr_count, rd_count         accepted writes/reads, wrapping
//   err_count                  SLVERR responses issued, saturating
module axi_lite_reg_responder #(
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'hA000_0000,
    parameter logic [DATA_W-1:0]   ID_VALUE  = 32'hA1B0_0001
) (
    input  logic                clk_wr,
    input  logic                rst_wr_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic [15:0]         wr_count,
    output logic [15:0]         rd_count,
    output logic [15:0]         err_count
);
    localparam int unsigned       IW   = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * 4);

    logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                awready_q, wready_q, arready_q;
    logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [15:0]         wr_cnt_q, rd_cnt_q, err_cnt_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W-1:0]   w_off, r_off;
    logic [IW-1:0]       w_idx, r_idx;
    logic                w_ok, r_ok, w_good;
    logic                aw_hs, w_hs, ar_hs, commit, w_err, r_err;
    logic [16:0]         err_sum;

    always_comb begin
        w_off     = aw_addr_q - BASE_ADDR;
        r_off     = araddr - BASE_ADDR;
        w_idx     = w_off[IW+1:2];
        r_idx     = r_off[IW+1:2];
        w_ok      = w_off < SPAN && aw_addr_q[1:0] == 2'b00;
        r_ok      = r_off < SPAN && araddr[1:0] == 2'b00;
        w_good    = w_ok && w_idx != '0;
        aw_hs     = awvalid && awready_q;
        w_hs      = wvalid && wready_q;
        ar_hs     = arvalid && arready_q;
        // a write only commits once its response slot is free or being drained
        commit    = aw_held_q && w_held_q && (!bvalid_q || bready);
        w_err     = commit && !w_good;
        r_err     = ar_hs && !r_ok;
        aw_held_d = commit ? 1'b0 : aw_held_q || aw_hs;
        w_held_d  = commit ? 1'b0 : w_held_q || w_hs;
        bvalid_d  = commit || (bvalid_q && !bready);
        rvalid_d  = ar_hs || (rvalid_q && !rready);
        err_sum   = {1'b0, err_cnt_q} + 17'(w_err) + 17'(r_err);
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            // readies are registered copies of the next-state flags so they stay low through reset
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
            arready_q <= !rvalid_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                bresp_q  <= w_good ? 2'b00 : 2'b10;
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            // regs_q is sampled before this edge's write lands, so a colliding read sees the old value
            if (ar_hs) begin
                rdata_q  <= !r_ok ? '0 : r_idx == '0 ? ID_VALUE : regs_q[r_idx];
                rresp_q  <= r_ok ? 2'b00 : 2'b10;
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (commit && w_good) begin
            for (int b = 0; b < DATA_W / 8; b++)
                if (wstrb_q[b]) regs_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign arready   = arready_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign rvalid    = rvalid_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// tb_axi_lite_reg_responder: scoreboard-driven bench for axi_lite_reg_responder.
module tb_axi_lite_reg_responder;
    localparam logic [31:0] BASE = 32'hA000_0000;
    localparam logic [31:0] ID   = 32'hA1B0_0001;

    logic        clk_wr = 1'b0, rst_wr_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] wr_count, rd_count, err_count;

    int checks = 0, failures = 0;
    logic [31:0] model [16];
    int m_wr = 0, m_rd = 0, m_err = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    axi_lite_reg_responder dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    always #5 clk_wr = ~clk_wr;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o < 32'd64 && a[1:0] == 2'b00;
    endfunction

    function automatic logic [3:0] addr_idx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[5:2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = '0;
        m_wr = 0;
        m_rd = 0;
        m_err = 0;
        bq.delete();
        rq.delete();
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (addr_ok(a) && addr_idx(a) != 4'd0) begin
            bq.push_back(2'b00);
            for (int b = 0; b < 4; b++)
                if (s[b]) model[addr_idx(a)][8*b +: 8] = d[8*b +: 8];
        end else begin
            bq.push_back(2'b10);
            m_err++;
        end
        m_wr++;
    endtask

    task automatic exp_read(input logic [31:0] a);
        if (!addr_ok(a)) begin
            rq.push_back({32'h0, 2'b10});
            m_err++;
        end else if (addr_idx(a) == 4'd0) rq.push_back({ID, 2'b00});
        else rq.push_back({model[addr_idx(a)], 2'b00});
        m_rd++;
    endtask

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        awaddr = a;
        awvalid = 1'b1;
        for (int i = 0; i < 50 && !awready; i++) step();
        if (!awready) begin
            failures++;
            $display("FAIL aw_timeout got awready=%b exp=1", awready);
        end
        step();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        for (int i = 0; i < 50 && !wready; i++) step();
        if (!wready) begin
            failures++;
            $display("FAIL w_timeout got wready=%b exp=1", wready);
        end
        step();
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        exp_read(a);
        araddr = a;
        arvalid = 1'b1;
        for (int i = 0; i < 50 && !arready; i++) step();
        if (!arready) begin
            failures++;
            $display("FAIL ar_timeout got arready=%b exp=1", arready);
        end
        step();
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_write(a, d, s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic get_b(output logic [1:0] r);
        bready = 1'b1;
        for (int i = 0; i < 50 && !bvalid; i++) step();
        r = bvalid ? bresp : 2'bxx;
        step();
        bready = 1'b0;
    endtask

    task automatic get_r(output logic [33:0] r);
        rready = 1'b1;
        for (int i = 0; i < 50 && !rvalid; i++) step();
        r = rvalid ? {rdata, rresp} : 'x;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_wr_n = 1'b0;
        step();
        step();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {awready, wready, arready, bvalid, rvalid, bresp, rresp});
        end
        checks++;
        if ({rdata, wr_count, rd_count, err_count} !== 80'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {rdata, wr_count, rd_count, err_count});
        end
        rst_wr_n = 1'b1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            failures++;
            $display("FAIL ready_before_edge got=%b exp=000", {awready, wready, arready});
        end
        step();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++;
            $display("FAIL ready_after_release got=%b exp=111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_read();
        logic [1:0] r;
        logic [33:0] rd, e;
        do_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF);
        get_b(r);
        checks++;
        if (r !== bq[0]) begin
            failures++;
            $display("FAIL wr_bresp got=%b exp=%b", r, bq[0]);
        end
        void'(bq.pop_front());
        send_ar(BASE + 32'h4);
        get_r(rd);
        e = rq.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL rd_back got=%h exp=%h", rd, e);
        end
        checks++;
        if ({wr_count, rd_count, err_count} !== {16'd1, 16'd1, 16'd0}) begin
            failures++;
            $display("FAIL counts_wr_rd got=%h exp=%h", {wr_count, rd_count, err_count}, {16'd1, 16'd1, 16'd0});
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r;
        logic [33:0] rd, e;
        do_write(BASE + 32'h4, 32'h0000_1234, 4'h3);
        get_b(r);
        e = {32'h0, bq.pop_front()};
        checks++;
        if (r !== e[1:0]) begin
            failures++;
            $display("FAIL strobe_bresp got=%b exp=%b", r, e[1:0]);
        end
        send_ar(BASE + 32'h4);
        get_r(rd);
        e = rq.pop_front();
        checks++;
        if (rd !== e || rd[33:2] !== 32'hDEAD_1234) begin
            failures++;
            $display("FAIL strobe_read got=%h exp=%h", rd, e);
        end
    endtask

    task automatic test_id_reg();
        logic [1:0] r, eb;
        logic [33:0] rd, e;
        send_ar(BASE);
        get_r(rd);
        e = rq.pop_front();
        checks++;
        if (rd !== e || rd !== {ID, 2'b00}) begin
            failures++;
            $display("FAIL id_read got=%h exp=%h", rd, e);
        end
        do_write(BASE, 32'h1234_5678, 4'hF);
        get_b(r);
        eb = bq.pop_front();
        checks++;
        if (r !== eb || r !== 2'b10) begin
            failures++;
            $display("FAIL id_write_bresp got=%b exp=%b", r, eb);
        end
        send_ar(BASE);
        get_r(rd);
        e = rq.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL id_unchanged got=%h exp=%h", rd, e);
        end
        checks++;
        if (err_count !== 16'(m_err) || err_count !== 16'd1) begin
            failures++;
            $display("FAIL id_err_count got=%0d exp=%0d", err_count, m_err);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r, eb;
        logic [33:0] rd, e;
        logic [31:0] addrs [2];
        addrs[0] = BASE + 32'h40;
        addrs[1] = BASE + 32'h6;
        for (int i = 0; i < 2; i++) begin
            send_ar(addrs[i]);
            get_r(rd);
            e = rq.pop_front();
            checks++;
            if (rd !== e || rd !== {32'h0, 2'b10}) begin
                failures++;
                $display("FAIL bad_read[%0d] got=%h exp=%h", i, rd, e);
            end
        end
        do_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
        get_b(r);
        eb = bq.pop_front();
        checks++;
        if (r !== eb || r !== 2'b10) begin
            failures++;
            $display("FAIL bad_write_bresp got=%b exp=%b", r, eb);
        end
        checks++;
        if (err_count !== 16'(m_err) || err_count !== 16'd4) begin
            failures++;
            $display("FAIL err_count_total got=%0d exp=%0d", err_count, m_err);
        end
        for (int i = 1; i < 16; i += 7) begin
            send_ar(BASE + 32'(i * 4));
            get_r(rd);
            e = rq.pop_front();
            checks++;
            if (rd !== e) begin
                failures++;
                $display("FAIL regs_intact[%0d] got=%h exp=%h", i, rd, e);
            end
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r, eb;
        exp_write(BASE + 32'h8, 32'h55AA_33CC, 4'hF);
        send_w(32'h55AA_33CC, 4'hF);
        checks++;
        if (wready !== 1'b0) begin
            failures++;
            $display("FAIL wready_held got=%b exp=0", wready);
        end
        step();
        step();
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL no_b_without_aw got=%b exp=0", bvalid);
        end
        awaddr = BASE + 32'h8;
        awvalid = 1'b1;
        checks++;
        if (awready !== 1'b1) begin
            failures++;
            $display("FAIL awready_idle got=%b exp=1", awready);
        end
        step();
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL b_early got=%b exp=0", bvalid);
        end
        step();
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL b_latency got=%b exp=1", bvalid);
        end
        get_b(r);
        eb = bq.pop_front();
        checks++;
        if (r !== eb) begin
            failures++;
            $display("FAIL late_aw_bresp got=%b exp=%b", r, eb);
        end
    endtask

    task automatic test_b_backpressure();
        logic [1:0] e1, e2;
        do_write(BASE + 32'hC, 32'h1111_2222, 4'hF);
        e1 = bq.pop_front();
        for (int i = 0; i < 50 && !bvalid; i++) step();
        checks++;
        if (bvalid !== 1'b1 || bresp !== e1) begin
            failures++;
            $display("FAIL bp_first got=%b%b exp=1%b", bvalid, bresp, e1);
        end
        do_write(BASE + 32'h44, 32'h9999_9999, 4'hF);
        e2 = bq.pop_front();
        checks++;
        if ({awready, wready} !== 2'b00) begin
            failures++;
            $display("FAIL bp_second_held got=%b exp=00", {awready, wready});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bvalid, bresp} !== {1'b1, e1}) begin
                failures++;
                $display("FAIL bp_stable[%0d] got=%b exp=%b", i, {bvalid, bresp}, {1'b1, e1});
            end
        end
        bready = 1'b1;
        step();
        checks++;
        if ({bvalid, bresp} !== {1'b1, e2}) begin
            failures++;
            $display("FAIL bp_back_to_back got=%b exp=%b", {bvalid, bresp}, {1'b1, e2});
        end
        step();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained got=%b exp=0", bvalid);
        end
        checks++;
        if ({wr_count, rd_count, err_count} !== {16'(m_wr), 16'(m_rd), 16'(m_err)}) begin
            failures++;
            $display("FAIL bp_counts got=%h exp=%h", {wr_count, rd_count, err_count}, {16'(m_wr), 16'(m_rd), 16'(m_err)});
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] rd, e;
        send_aw(BASE + 32'h10);
        send_ar(BASE + 32'h4);
        checks++;
        if ({awready, rvalid} !== 2'b01) begin
            failures++;
            $display("FAIL mid_setup got=%b exp=01", {awready, rvalid});
        end
        #2;
        rst_wr_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_count, rd_count, err_count} !== 89'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_count, rd_count, err_count});
        end
        model_reset();
        step();
        rst_wr_n = 1'b1;
        step();
        for (int i = 1; i < 4; i++) begin
            send_ar(BASE + 32'(i * 4));
            get_r(rd);
            e = rq.pop_front();
            checks++;
            if (rd !== e || rd !== 34'h0) begin
                failures++;
                $display("FAIL post_reset_reg[%0d] got=%h exp=%h", i, rd, e);
            end
        end
        checks++;
        if ({wr_count, rd_count, err_count} !== {16'd0, 16'd3, 16'd0}) begin
            failures++;
            $display("FAIL post_reset_counts got=%h exp=%h", {wr_count, rd_count, err_count}, {16'd0, 16'd3, 16'd0});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_id_reg();
        test_errors();
        test_w_before_aw();
        test_b_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
